// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state encoding for the serial ALU requester.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_X,
        ST_SEND_Y,
        ST_WAIT,
        ST_CAP_LO,
        ST_RESP
    } alu_drv_state_t;

endpackage

// File: rtl/alu_drv_timer.sv
// Watchdog counter for the WAIT phase: clears on request, counts while enabled,
// and parks at TIMEOUT-1 where the terminal flag is raised.
module alu_drv_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] countReg;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            countReg <= '0;
        end else if (enable && !terminal) begin
            countReg <= countReg + 1'b1;
        end
    end

    assign terminal = (countReg == CW'(TIMEOUT - 1));

endmodule

// File: rtl/alu_driver.sv
// Requester for the serial ALU: takes an operation upstream, streams operands,
// collects the two result words (or aborts on watchdog) and returns them upstream.
module alu_driver
    import alu_pkg::*;
#(
    parameter int w       = 8,
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [w-1:0] req_x,
    input  logic [w-1:0] req_y,
    input  logic [1:0]   req_op,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [w-1:0] resp_hi,
    output logic [w-1:0] resp_lo,
    output logic         resp_err,
    output logic [w-1:0] alu_in,
    output logic [1:0]   alu_op,
    output logic         alu_valid,
    output logic         alu_rst,
    input  logic [w-1:0] alu_o,
    input  logic         alu_ready
);

    alu_drv_state_t stateReg;
    logic [w-1:0]   yReg;
    logic           timeoutHit;

    alu_drv_timer #(.TIMEOUT(TIMEOUT)) watchdog (
        .clk      (clk),
        .rst      (rst),
        .clear    (stateReg == ST_SEND_Y),
        .enable   (stateReg == ST_WAIT),
        .terminal (timeoutHit)
    );

    // Every output is updated together with the state so it lines up with the state it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg   <= ST_IDLE;
            yReg       <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_hi    <= '0;
            resp_lo    <= '0;
            resp_err   <= 1'b0;
            alu_in     <= '0;
            alu_op     <= '0;
            alu_valid  <= 1'b0;
            alu_rst    <= 1'b0;
        end else begin
            alu_rst <= 1'b0;
            case (stateReg)
                ST_IDLE: begin
                    if (req_valid) begin
                        yReg      <= req_y;
                        req_ready <= 1'b0;
                        alu_valid <= 1'b1;
                        alu_in    <= req_x;
                        alu_op    <= req_op;
                        stateReg  <= ST_SEND_X;
                    end
                end
                ST_SEND_X: begin
                    alu_valid <= 1'b0;
                    alu_op    <= '0;
                    alu_in    <= yReg;
                    stateReg  <= ST_SEND_Y;
                end
                ST_SEND_Y: begin
                    alu_in   <= '0;
                    stateReg <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A finish strobe on the terminal cycle still counts as success.
                    if (alu_ready) begin
                        resp_hi  <= alu_o;
                        stateReg <= ST_CAP_LO;
                    end else if (timeoutHit) begin
                        alu_rst    <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_hi    <= '0;
                        resp_lo    <= '0;
                        resp_valid <= 1'b1;
                        stateReg   <= ST_RESP;
                    end
                end
                ST_CAP_LO: begin
                    resp_lo    <= alu_o;
                    resp_err   <= 1'b0;
                    resp_valid <= 1'b1;
                    stateReg   <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_hi    <= '0;
                        resp_lo    <= '0;
                        resp_err   <= 1'b0;
                        req_ready  <= 1'b1;
                        stateReg   <= ST_IDLE;
                    end
                end
                default: begin
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    alu_valid  <= 1'b0;
                    alu_in     <= '0;
                    alu_op     <= '0;
                    stateReg   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_driver.sv
// Directed bench for alu_driver with a hand-driven ALU model.
module tb_alu_driver;
    import alu_pkg::*;

    localparam int W = 8;
    localparam int T = 16;

    logic         clk;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_x;
    logic [W-1:0] req_y;
    logic [1:0]   req_op;
    logic         resp_valid;
    logic         resp_ready;
    logic [W-1:0] resp_hi;
    logic [W-1:0] resp_lo;
    logic         resp_err;
    logic [W-1:0] alu_in;
    logic [1:0]   alu_op;
    logic         alu_valid;
    logic         alu_rst;
    logic [W-1:0] alu_o;
    logic         alu_ready;

    int checks   = 0;
    int failures = 0;
    int rstPulses = 0;

    alu_driver #(.w(W), .TIMEOUT(T)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_op     (req_op),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_hi    (resp_hi),
        .resp_lo    (resp_lo),
        .resp_err   (resp_err),
        .alu_in     (alu_in),
        .alu_op     (alu_op),
        .alu_valid  (alu_valid),
        .alu_rst    (alu_rst),
        .alu_o      (alu_o),
        .alu_ready  (alu_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (alu_rst === 1'b1) rstPulses++;
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hands one request over and walks through SEND_X/SEND_Y; returns in the SEND_Y cycle.
    task automatic issue(input logic [7:0] x, input logic [7:0] y, input logic [1:0] op, input bit keep);
        int n;
        req_x = x;
        req_y = y;
        req_op = op;
        req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checkVal("req_ready_wait", 32'(req_ready), 32'd1);
        step();
        if (keep) begin
            req_x = ~x;
            req_y = ~y;
        end else begin
            req_valid = 1'b0;
        end
        checkVal("sendx_valid", 32'(alu_valid), 32'd1);
        checkVal("sendx_in", 32'(alu_in), 32'(x));
        checkVal("sendx_op", 32'(alu_op), 32'(op));
        checkVal("sendx_req_ready", 32'(req_ready), 32'd0);
        step();
        checkVal("sendy_valid", 32'(alu_valid), 32'd0);
        checkVal("sendy_in", 32'(y), 32'(alu_in));
        checkVal("sendy_op", 32'(alu_op), 32'd0);
    endtask

    // ALU model: enters WAIT, raises alu_ready with timer == delay, then supplies the low word.
    task automatic finishOp(input int delay, input logic [7:0] hi, input logic [7:0] lo);
        step();
        alu_ready = 1'b0;
        alu_o = '0;
        repeat (delay) step();
        alu_ready = 1'b1;
        alu_o = hi;
        step();
        alu_ready = 1'b0;
        alu_o = lo;
        checkVal("caplo_no_resp", 32'(resp_valid), 32'd0);
        step();
        alu_o = '0;
    endtask

    task automatic checkResp(input string tag, input logic [7:0] hi, input logic [7:0] lo, input logic err);
        checkVal({tag, "_valid"}, 32'(resp_valid), 32'd1);
        checkVal({tag, "_hi"}, 32'(resp_hi), 32'(hi));
        checkVal({tag, "_lo"}, 32'(resp_lo), 32'(lo));
        checkVal({tag, "_err"}, 32'(resp_err), 32'(err));
        $display("txn %s: hi=0x%02h lo=0x%02h err=%0b", tag, resp_hi, resp_lo, resp_err);
    endtask

    task automatic handshake();
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        checkVal("post_hs_resp_valid", 32'(resp_valid), 32'd0);
        checkVal("post_hs_req_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        int k;
        int pulsesBefore;
        rst = 1'b1;
        req_valid = 1'b0;
        req_x = '0;
        req_y = '0;
        req_op = '0;
        resp_ready = 1'b0;
        alu_o = '0;
        alu_ready = 1'b0;
        step();
        step();
        rst = 1'b0;

        checkVal("reset_req_ready", 32'(req_ready), 32'd1);
        checkVal("reset_outs", {resp_valid, resp_err, alu_valid, alu_rst, alu_op, alu_in, resp_hi, resp_lo}, 32'd0);
        $display("txn reset: req_ready=%0b", req_ready);

        // 1: mul 5*7
        issue(8'd5, 8'd7, OP_MUL, 1'b0);
        finishOp(8, 8'h00, 8'h23);
        checkResp("mul", 8'h00, 8'h23, 1'b0);
        handshake();

        // 2: div 100/7 with a stalled consumer
        issue(8'd100, 8'd7, OP_DIV, 1'b0);
        finishOp(5, 8'h02, 8'h0E);
        checkResp("div", 8'h02, 8'h0E, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            checkVal("stall_resp", {15'd0, resp_valid, resp_hi, resp_lo}, {15'd0, 1'b1, 8'h02, 8'h0E});
            checkVal("stall_req_ready", 32'(req_ready), 32'd0);
        end
        handshake();

        // 3: ALU never finishes
        pulsesBefore = rstPulses;
        issue(8'h12, 8'h34, OP_SUB, 1'b0);
        step();
        k = 0;
        while (resp_valid !== 1'b1 && k < 3 * T) begin
            step();
            k++;
        end
        checkVal("timeout_wait_cycles", 32'(k), 32'(T));
        checkVal("timeout_alu_rst", 32'(alu_rst), 32'd1);
        checkResp("timeout", 8'h00, 8'h00, 1'b1);
        handshake();
        checkVal("timeout_alu_rst_off", 32'(alu_rst), 32'd0);
        checkVal("timeout_pulse_count", 32'(rstPulses - pulsesBefore), 32'd1);

        // 4: finish strobe on the final WAIT cycle
        pulsesBefore = rstPulses;
        issue(8'h40, 8'h02, OP_ADD, 1'b0);
        finishOp(T - 1, 8'h00, 8'h42);
        checkResp("last_cycle", 8'h00, 8'h42, 1'b0);
        handshake();
        checkVal("last_cycle_no_rst", 32'(rstPulses - pulsesBefore), 32'd0);

        // 5: reset while waiting, then a late ALU strobe
        pulsesBefore = rstPulses;
        issue(8'h11, 8'h22, OP_ADD, 1'b0);
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkVal("midrst_req_ready", 32'(req_ready), 32'd1);
        checkVal("midrst_outs", {29'd0, alu_valid, alu_rst, resp_valid}, 32'd0);
        alu_ready = 1'b1;
        alu_o = 8'h99;
        step();
        alu_ready = 1'b0;
        alu_o = '0;
        step();
        checkVal("midrst_late_ready", {30'd0, resp_valid, req_ready}, 32'd1);
        checkVal("midrst_no_alu_rst", 32'(rstPulses - pulsesBefore), 32'd0);
        $display("txn midrst: req_ready=%0b resp_valid=%0b", req_ready, resp_valid);

        // 6: back-to-back adds with req_valid held, spurious strobe in SEND_Y
        issue(8'd3, 8'd4, OP_ADD, 1'b1);
        alu_ready = 1'b1;
        alu_o = 8'h55;
        finishOp(3, 8'h00, 8'h07);
        checkResp("add1", 8'h00, 8'h07, 1'b0);
        req_x = 8'd9;
        req_y = 8'd1;
        handshake();
        issue(8'd9, 8'd1, OP_ADD, 1'b0);
        finishOp(2, 8'h00, 8'h0A);
        checkResp("add2", 8'h00, 8'h0A, 1'b0);
        handshake();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
